sensor_arbiter: RTL and testbench

SENSOR_ARBITER -- requirements
Module: sensor_arbiter

---
 rtl/sensor_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/sensor_arbiter.sv | 133 +++++++++++++
 tb/tb_sensor_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_arb_pkg.sv
// Shared definitions for the sensor arbiter: default channel count and
// word width, sensor-id width and the output FSM state encoding.
package sensor_arb_pkg;

    localparam int NUM_SENSORS_DEF = 16;
    localparam int DATA_W_DEF      = 32;
    localparam int ID_W            = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or after ptr.
// Ports: req (requests), ptr (search start) -> grant (one-hot), idx, any.
module rr_arbiter #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < N; i++) begin
            int c;
            c = int'(ptr) + i;
            // wrap the rotated position back into 0..N-1
            if (c >= N) c = c - N;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/sensor_arbiter.sv
// Collects one-cycle sensor strobes into holding registers and streams
// them round-robin into a single registered output with write/ready.
// Ports: clk, reset (async, high), sensor_data, data_available, ready,
//   overflow_clear -> sensor_value_out, sensor_id, write, overflow.
// Option SENSOR_ARB_DROP_COUNT_EN adds a saturating drop_count output.
module sensor_arbiter
    import sensor_arb_pkg::*;
#(
    parameter int NUM_SENSORS = NUM_SENSORS_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SENSORS*DATA_W-1:0] sensor_data,
    input  logic [NUM_SENSORS-1:0]        data_available,
    input  logic                          ready,
    input  logic                          overflow_clear,
    output logic [DATA_W-1:0]             sensor_value_out,
    output logic [ID_W-1:0]               sensor_id,
    output logic                          write,
    output logic [NUM_SENSORS-1:0]        overflow
`ifdef SENSOR_ARB_DROP_COUNT_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    state_t state;
    state_t state_nxt;

    logic [NUM_SENSORS-1:0] pending;
    logic [NUM_SENSORS-1:0] grant;
    logic [NUM_SENSORS-1:0] gnt_mask;
    logic [NUM_SENSORS-1:0] ovf_set;
    logic [DATA_W-1:0]      hold [NUM_SENSORS];
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        ptr_nxt;
    logic [ID_W-1:0]        gnt_idx;
    logic                   any_gnt;
    logic                   take;

    rr_arbiter #(
        .N     (NUM_SENSORS),
        .IDX_W (ID_W)
    ) u_rr (
        .req   (pending),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (any_gnt)
    );

    // take: a pending word moves into the output registers this edge
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_gnt) begin
                    take      = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (ready) begin
                    if (any_gnt) take = 1'b1;
                    else         state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign gnt_mask = take ? grant : '0;
    // a re-strobe on the channel being granted is a fresh word, not a drop
    assign ovf_set  = data_available & pending & ~gnt_mask;
    assign ptr_nxt  = (gnt_idx == ID_W'(NUM_SENSORS - 1)) ? '0
                                                          : gnt_idx + ID_W'(1);
    assign write    = (state == VALID);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sensor_value_out <= '0;
            sensor_id        <= '0;
            ptr              <= '0;
            pending          <= '0;
            overflow         <= '0;
        end else begin
            if (take) begin
                sensor_value_out <= hold[gnt_idx];
                sensor_id        <= gnt_idx;
                ptr              <= ptr_nxt;
            end
            pending <= (pending & ~gnt_mask) | data_available;
            if (overflow_clear) overflow <= '0;
            else                overflow <= overflow | ovf_set;
        end
    end

    // holding registers carry no reset; pending guards their validity
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_SENSORS; k++) begin
            if (data_available[k])
                hold[k] <= sensor_data[k*DATA_W +: DATA_W];
        end
    end

`ifdef SENSOR_ARB_DROP_COUNT_EN
    logic [15:0] drop_inc;
    logic [16:0] drop_sum;

    always_comb begin
        drop_inc = '0;
        for (int k = 0; k < NUM_SENSORS; k++)
            drop_inc = drop_inc + 16'(ovf_set[k]);
    end

    assign drop_sum = {1'b0, drop_count} + {1'b0, drop_inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               drop_count <= '0;
        else if (overflow_clear) drop_count <= '0;
        else if (drop_sum[16])   drop_count <= 16'hFFFF;
        else                     drop_count <= drop_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_sensor_arbiter.sv
// Self-checking bench for sensor_arbiter: directed scenarios followed by
// randomized traffic compared against a per-channel behavioural model.
module tb_sensor_arbiter;

    localparam int N = 16;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N*W-1:0] sensor_data = '0;
    logic [N-1:0]   data_available = '0;
    logic           ready = 1'b0;
    logic           overflow_clear = 1'b0;
    logic [W-1:0]   sensor_value_out;
    logic [3:0]     sensor_id;
    logic           write;
    logic [N-1:0]   overflow;
`ifdef SENSOR_ARB_DROP_COUNT_EN
    logic [15:0]    drop_count;
`endif

    sensor_arbiter #(.NUM_SENSORS(N), .DATA_W(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .sensor_data      (sensor_data),
        .data_available   (data_available),
        .ready            (ready),
        .overflow_clear   (overflow_clear),
        .sensor_value_out (sensor_value_out),
        .sensor_id        (sensor_id),
        .write            (write),
        .overflow         (overflow)
`ifdef SENSOR_ARB_DROP_COUNT_EN
        ,
        .drop_count       (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // behavioural model: what the downstream side should see
    bit          m_valid;
    logic [31:0] m_val;
    logic [3:0]  m_id;
    bit          m_pend [N];
    logic [31:0] m_hold [N];
    logic [15:0] m_ovf;
    int          m_ptr;
    int          m_drops;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_val   = '0;
        m_id    = '0;
        m_ovf   = '0;
        m_ptr   = 0;
        m_drops = 0;
        for (int k = 0; k < N; k++) m_pend[k] = 0;
    endtask

    task automatic model_step(input logic [N-1:0] da, input bit rdy,
                              input bit clr);
        int g;
        int cnt;
        bit old [N];
        logic [15:0] newovf;
        g = -1;
        cnt = 0;
        newovf = '0;
        old = m_pend;
        if (!m_valid || rdy) begin
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_ptr + j) % N;
                if (g < 0 && old[c]) g = c;
            end
            if (g >= 0) begin
                m_val     = m_hold[g];
                m_id      = 4'(g);
                m_valid   = 1;
                m_ptr     = (g + 1) % N;
                m_pend[g] = 0;
            end else begin
                m_valid = 0;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (da[k]) begin
                if (old[k] && k != g) begin
                    newovf[k] = 1'b1;
                    cnt++;
                end
                m_hold[k] = sensor_data[k*W +: W];
                m_pend[k] = 1;
            end
        end
        if (clr) begin
            m_ovf   = '0;
            m_drops = 0;
        end else begin
            m_ovf   = m_ovf | newovf;
            m_drops = (m_drops + cnt > 65535) ? 65535 : m_drops + cnt;
        end
    endtask

    task automatic check_model();
        chk("write", 64'(write), 64'(m_valid));
        chk("value", 64'(sensor_value_out), 64'(m_val));
        chk("id", 64'(sensor_id), 64'(m_id));
        chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef SENSOR_ARB_DROP_COUNT_EN
        chk("drop_count", 64'(drop_count), 64'(m_drops));
`endif
    endtask

    // one clock: drive, let the edge happen, advance model, compare
    task automatic cyc(input logic [N-1:0] da, input bit rdy, input bit clr);
        data_available = da;
        ready          = rdy;
        overflow_clear = clr;
        @(posedge clk);
        model_step(da, rdy, clr);
        #1;
        check_model();
        data_available = '0;
        overflow_clear = 1'b0;
    endtask

    task automatic set_word(input int k, input logic [31:0] v);
        sensor_data[k*W +: W] = v;
    endtask

    task automatic do_reset(input string tag);
        data_available = '0;
        overflow_clear = 1'b0;
        reset = 1'b1;
        #2;
        chk({tag, "_write"}, 64'(write), 64'(0));
        chk({tag, "_value"}, 64'(sensor_value_out), 64'(0));
        chk({tag, "_id"}, 64'(sensor_id), 64'(0));
        chk({tag, "_ovf"}, 64'(overflow), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        #3;
        do_reset("rst0");

        // single strobe on channel 3, one-cycle latency, one write
        set_word(3, 32'h0000_1234);
        cyc(16'h0008, 1, 0);
        chk("c3_lat0", 64'(write), 64'(0));
        cyc(16'h0000, 1, 0);
        chk("c3_write", 64'(write), 64'(1));
        chk("c3_val", 64'(sensor_value_out), 64'h1234);
        chk("c3_id", 64'(sensor_id), 64'(3));
        cyc(16'h0000, 1, 0);
        chk("c3_once", 64'(write), 64'(0));

        // channels 0, 5, 15 together from reset pointer
        do_reset("rst1");
        set_word(0, 32'hA000_0000);
        set_word(5, 32'hA000_0005);
        set_word(15, 32'hA000_000F);
        cyc(16'h8021, 1, 0);
        cyc(16'h0000, 1, 0);
        chk("m_id0", 64'(sensor_id), 64'(0));
        chk("m_w0", 64'(write), 64'(1));
        cyc(16'h0000, 1, 0);
        chk("m_id5", 64'(sensor_id), 64'(5));
        chk("m_w5", 64'(write), 64'(1));
        cyc(16'h0000, 1, 0);
        chk("m_id15", 64'(sensor_id), 64'(15));
        chk("m_w15", 64'(write), 64'(1));
        cyc(16'h0000, 1, 0);
        chk("m_idle", 64'(write), 64'(0));

        // wrap-around: last grant 14, then 1 and 15
        set_word(14, 32'h0000_00EE);
        cyc(16'h4000, 1, 0);
        cyc(16'h0000, 1, 0);
        chk("wr_id14", 64'(sensor_id), 64'(14));
        set_word(1, 32'h0000_0011);
        set_word(15, 32'h0000_00FF);
        cyc(16'h8002, 1, 0);
        cyc(16'h0000, 1, 0);
        chk("wr_id15", 64'(sensor_id), 64'(15));
        cyc(16'h0000, 1, 0);
        chk("wr_id1", 64'(sensor_id), 64'(1));
        cyc(16'h0000, 1, 0);

        // channel 2 overwritten while output is stalled
        set_word(7, 32'h0000_0777);
        cyc(16'h0080, 0, 0);
        cyc(16'h0000, 0, 0);
        set_word(2, 32'h0000_000A);
        cyc(16'h0004, 0, 0);
        set_word(2, 32'h0000_000B);
        cyc(16'h0004, 0, 0);
        chk("ov_flag", 64'(overflow), 64'h0004);
        cyc(16'h0000, 1, 0);
        chk("ov_val", 64'(sensor_value_out), 64'h000B);
        chk("ov_id", 64'(sensor_id), 64'(2));
        cyc(16'h0000, 1, 0);
        chk("ov_single", 64'(write), 64'(0));
        cyc(16'h0000, 1, 1);
        chk("ov_clear", 64'(overflow), 64'(0));

        // stall for 10 cycles, outputs must hold
        set_word(9, 32'hCAFE_0009);
        cyc(16'h0200, 0, 0);
        cyc(16'h0000, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(16'h0000, 0, 0);
            chk("st_val", 64'(sensor_value_out), 64'hCAFE_0009);
            chk("st_w", 64'(write), 64'(1));
        end
        cyc(16'h0000, 1, 0);
        chk("st_done", 64'(write), 64'(0));

        // reset mid-transfer with four channels pending
        cyc(16'h0001, 0, 0);
        cyc(16'h0000, 0, 0);
        cyc(16'h1C10, 0, 0);
        chk("rs_pre", 64'(write), 64'(1));
        do_reset("rst2");
        for (int i = 0; i < 5; i++) begin
            cyc(16'h0000, 1, 0);
            chk("rs_quiet", 64'(write), 64'(0));
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] da;
            for (int k = 0; k < N; k++) begin
                set_word(k, $urandom);
                da[k] = ($urandom_range(0, 9) == 0);
            end
            cyc(da, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
